// File: rtl/usart_tx_even_parity.sv
// USART transmitter, 8 data bits LSB first, even parity, one stop bit.
// Frame: start(0), d0..d7, parity (XOR of data), stop(1); each bit lasts
// CLKS_PER_BIT clock cycles. One byte is accepted per frame, only while idle.
module usart_tx_even_parity #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bit_done;

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;

  // Next-state logic: baud timing, bit sequencing and the next tx level.
  // tx_d always reflects the bit that the next state will put on the line,
  // so the serial output is registered without a cycle of extra latency.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    bit_done  = (cnt_q == CNT_LAST);

    if (state_q == IDLE || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d   = tx_data;
          parity_d  = ^tx_data;
          bit_idx_d = 3'd0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset wins over an accept on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_usart_tx_even_parity.sv
// Testbench for usart_tx_even_parity with CLKS_PER_BIT = 4.
// Expected line levels come from the frame layout {stop, parity, data, start};
// a mid-bit sampling receiver re-assembles each frame and checks its parity.
module tb_usart_tx_even_parity;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usart_tx_even_parity #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  // Offer byte b while idle, then follow the whole frame cycle by cycle.
  // hold: keep tx_valid high and present next_b for a back-to-back frame.
  // disturb: change tx_data and pulse tx_valid in the middle of the frame.
  // exp_par: literal parity expectation, or -1 to rely on the model only.
  task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] next_b,
                           input bit disturb, input int exp_par, input string tag);
    logic [10:0] f;
    logic [10:0] rx;
    f  = frame_of(b);
    rx = '0;
    chk1({tag, ":ready_before"}, tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    if (hold) tx_data = next_b;
    else      tx_valid = 1'b0;
    for (int j = 0; j < 11 * CPB; j++) begin
      chk1({tag, ":tx"}, tx, f[j / CPB]);
      chk1({tag, ":busy"}, tx_busy, 1'b1);
      chk1({tag, ":ready"}, tx_ready, 1'b0);
      if (j % CPB == CPB / 2) rx[j / CPB] = tx;
      if (disturb && j == 5 * CPB) begin
        tx_data  = ~b;
        tx_valid = 1'b1;
      end
      if (disturb && j == 5 * CPB + 1) tx_valid = 1'b0;
      tick();
    end
    chk1({tag, ":tx_after"}, tx, 1'b1);
    chk1({tag, ":ready_after"}, tx_ready, 1'b1);
    chk1({tag, ":busy_after"}, tx_busy, 1'b0);
    chk1({tag, ":rx_start"}, rx[0], 1'b0);
    chk1({tag, ":rx_stop"}, rx[10], 1'b1);
    chk1({tag, ":rx_parity_check"}, ^rx[9:1], 1'b0);
    chk8({tag, ":rx_data"}, rx[8:1], b);
    if (exp_par >= 0) chk1({tag, ":parity_bit"}, rx[9], exp_par[0]);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk1({tag, ":idle_tx"}, tx, 1'b1);
      chk1({tag, ":idle_busy"}, tx_busy, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk1("reset:tx", tx, 1'b1);
    chk1("reset:ready", tx_ready, 1'b1);
    chk1("reset:busy", tx_busy, 1'b0);
    tick();

    run_frame(8'hA5, 1'b0, 8'h00, 1'b0, 0, "a5");
    run_frame(8'h07, 1'b0, 8'h00, 1'b0, 1, "x07");
    run_frame(8'h00, 1'b0, 8'h00, 1'b0, 0, "x00");
    run_frame(8'hFF, 1'b0, 8'h00, 1'b0, 0, "xff");

    // Back-to-back: valid stays high; the second call starts on the single
    // idle cycle and its first sample must already be the start bit.
    run_frame(8'h3C, 1'b1, 8'hC3, 1'b0, 0, "b2b_first");
    run_frame(8'hC3, 1'b0, 8'h00, 1'b0, 0, "b2b_second");

    run_frame(8'h5A, 1'b0, 8'h00, 1'b1, -1, "disturb");
    idle_cycles(8, "no_second_frame");

    // Reset during data bit 3.
    f        = frame_of(8'h96);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int j = 0; j < 4 * CPB + 1; j++) begin
      chk1("partial:tx", tx, f[j / CPB]);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midreset:tx", tx, 1'b1);
    chk1("midreset:busy", tx_busy, 1'b0);
    chk1("midreset:ready", tx_ready, 1'b1);
    idle_cycles(8, "midreset");
    run_frame(8'h55, 1'b0, 8'h00, 1'b0, 0, "after_reset");

    // Reset and accept on the same edge: byte is dropped.
    rst      = 1'b1;
    tx_data  = 8'hE1;
    tx_valid = 1'b1;
    tick();
    rst      = 1'b0;
    tx_valid = 1'b0;
    chk1("rst_vs_accept:tx", tx, 1'b1);
    chk1("rst_vs_accept:ready", tx_ready, 1'b1);
    chk1("rst_vs_accept:busy", tx_busy, 1'b0);
    idle_cycles(6, "rst_vs_accept");

    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      run_frame(b, 1'b0, 8'h00, 1'b0, -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usart_tx_even_parity.md
USART_TX_EVEN_PARITY -- requirements
Module: usart_tx_even_parity

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, which sets the clock cycles per serial bit; legal values are 2 or more.
REQ-002 SHALL have clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have tx_data, input, 8 bits: the byte to transmit, sampled on the accept cycle.
REQ-005 SHALL have tx_valid, input, 1 bit: the producer has a byte available.
REQ-006 SHALL have tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-007 SHALL have tx, output, 1 bit: the serial line; idle level is 1.
REQ-008 SHALL have tx_busy, output, 1 bit: a frame is in progress.

Function
REQ-009 SHALL transmit an 11-bit frame: start bit (0), data bits 0 through 7 LSB first, parity bit, stop bit (1).
REQ-010 SHALL set parity = XOR of the 8 latched data bits, so the 9-bit {parity, data} word has an even number of ones; the receiver's even-parity checker over that word then yields 0.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, registered; no other reachable state.
REQ-012 SHALL drive tx_ready = 1 only in IDLE, and tx_busy = 1 in every state except IDLE.
REQ-013 SHALL define accept as tx_valid && tx_ready at a rising edge; on accept it SHALL latch tx_data into a shift register, compute parity, and go to START.
REQ-014 SHALL ignore tx_data and tx_valid outside the accept cycle; input changes mid-frame SHALL NOT affect the frame.
REQ-015 SHALL register tx; tx SHALL be 0 from the cycle after accept.
REQ-016 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and clears at each bit boundary.
REQ-017 SHALL move START -> DATA when the counter hits terminal count.
REQ-018 SHALL use a 3-bit bit index in DATA and leave DATA for PARITY after bit index 7 reaches terminal count.
REQ-019 SHALL move PARITY -> STOP, then STOP -> IDLE, each at terminal count.
REQ-020 SHALL make the frame occupy tx for exactly 11*CLKS_PER_BIT cycles from the cycle after accept.
REQ-021 SHALL hold tx = 1 in IDLE.
REQ-022 SHALL, with tx_valid held high continuously, accept the next byte in the first IDLE cycle, giving exactly 1 extra idle-high cycle between frames.
REQ-023 SHALL NOT accept or queue a byte while busy; there is no buffering beyond the single shift register.

Reset
REQ-024 SHALL, on any cycle with rst = 1, set the following on the next edge regardless of state, including mid-frame: state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0, baud counter = 0, bit index = 0, shift register = 0.
REQ-025 SHALL give rst priority over accept when both occur on the same edge; that byte is dropped.
REQ-026 SHALL NOT emit a partial frame remnant after reset releases; tx stays 1 until a new accept.

Verification (CLKS_PER_BIT = 4)
REQ-027 SHALL cover this case: reset, then tx_data = 0xA5 with a 1-cycle tx_valid -> tx = 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each held 4 cycles; 44 cycles total; then tx_ready = 1.
REQ-028 SHALL cover this case: tx_data = 0x07 -> data bits 1,1,1,0,0,0,0,0 and parity bit 1.
REQ-029 SHALL cover this case: tx_data = 0x00 -> parity bit 0; tx_data = 0xFF -> parity bit 0.
REQ-030 SHALL cover this case: tx_valid held high with bytes 0x3C then 0xC3 -> two back-to-back frames with exactly one tx = 1 cycle between the stop bit and the second start bit; tx_ready pulses for exactly 1 cycle.
REQ-031 SHALL cover this case: rst asserted for 1 cycle during data bit 3 -> tx = 1, tx_busy = 0, tx_ready = 1 on the next cycle; a new 0x55 frame afterwards is bit-exact.
REQ-032 SHALL cover this case: tx_data changed and tx_valid pulsed mid-frame -> the frame is unchanged and no second frame is sent.
REQ-033 SHALL cover this case: loopback into the team's even-parity receiver/checker for 256 random bytes -> every frame checks 0 and the data matches.
